// File: rtl/if_prefetch.sv
// if_prefetch: fetch stage with a decoupled prefetch queue and redirect squash.
// Define IF_ADEF_EN to turn misaligned fetch PCs into queued fetch exceptions.
module if_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_excp,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);

  typedef logic [AW:0] cnt_t;

  logic [31:0]   fetch_pc;
  logic [31:0]   pcf [DEPTH];
  logic [AW-1:0] pcf_wr;
  logic [AW-1:0] pcf_rd;

  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   q_inst [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  cnt_t          count;

  cnt_t          inflight;
  cnt_t          inflight_nxt;
  cnt_t          cancel;

  logic [AW+1:0] used;
  logic          credit;
  logic          acc;
  logic          keep;
  logic          drop;
  logic          push;
  logic          pop;
  logic          fetch_ok;
  logic          adef_push;
  logic [31:0]   target;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst;

  assign used   = {1'b0, count} + {1'b0, inflight};
  assign credit = used < LIMIT;

`ifdef IF_ADEF_EN
  logic halt;
  logic misalign;
  logic q_excp [DEPTH];

  assign misalign  = fetch_pc[1:0] != 2'b00;
  assign fetch_ok  = !halt && !misalign;
  // The exception entry must queue behind every response still in flight.
  assign adef_push = !rst && !br_taken && !halt && credit && misalign &&
                     (inflight == '0);
  assign target    = br_target;
  assign out_excp  = q_excp[head];

  always_ff @(posedge clk) begin
    if (rst || br_taken) begin
      halt <= 1'b0;
    end else if (adef_push) begin
      halt <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_excp[i] <= 1'b0;
      end
    end else if (push && !br_taken) begin
      q_excp[tail] <= adef_push;
    end
  end
`else
  assign fetch_ok  = 1'b1;
  assign adef_push = 1'b0;
  assign target    = br_target & 32'hFFFF_FFFC;
  assign out_excp  = 1'b0;
`endif

  assign inst_sram_req  = !rst && !br_taken && fetch_ok && credit;
  assign inst_sram_addr = fetch_pc;

  assign acc  = inst_sram_req && inst_sram_addr_ok;
  assign drop = inst_sram_data_ok && (cancel != '0);
  assign keep = inst_sram_data_ok && (cancel == '0) && !br_taken;
  assign push = keep || adef_push;
  assign pop  = out_valid && out_ready && !br_taken;

  assign push_pc   = adef_push ? fetch_pc : pcf[pcf_rd];
  assign push_inst = adef_push ? 32'h0 : inst_sram_rdata;

  assign inflight_nxt = inflight + cnt_t'(acc) -
                        cnt_t'(inst_sram_data_ok);

  assign out_valid = count != '0;
  assign out_pc    = q_pc[head];
  assign out_inst  = q_inst[head];

  always_ff @(posedge clk) begin
    if (acc) begin
      pcf[pcf_wr] <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pcf_wr   <= '0;
      pcf_rd   <= '0;
      inflight <= '0;
      cancel   <= '0;
    end else begin
      if (acc) begin
        pcf_wr <= pcf_wr + AW'(1);
      end
      // Every response pops its PC, kept or dropped, so order holds.
      if (inst_sram_data_ok) begin
        pcf_rd <= pcf_rd + AW'(1);
      end
      inflight <= inflight_nxt;
      if (br_taken) begin
        fetch_pc <= target;
        cancel   <= inflight_nxt;
      end else begin
        if (acc) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (drop) begin
          cancel <= cancel - cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= 32'h0;
        q_inst[i] <= 32'h0;
      end
    end else if (br_taken) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_pc[tail]   <= push_pc;
        q_inst[tail] <= push_inst;
        tail         <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      count <= count + cnt_t'(push) - cnt_t'(pop);
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: bus model plus scoreboard of expected queue outputs.
// Covers streaming, credit stall, redirect squash, excp entry and PC wrap.
module tb_if_prefetch;
  localparam logic [31:0] RPC = 32'h1c000000;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk;
  logic        rst;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_excp;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;

  if_prefetch #(.RESET_PC(RPC), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .out_excp(out_excp),
    .br_taken(br_taken),
    .br_target(br_target),
    .inst_sram_req(inst_sram_req),
    .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        stale;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  typedef struct {
    logic rdy;
    logic e_req;
    logic e_valid;
  } vec_t;

  pend_t       pend [$];
  ent_t        exp_q [$];
  logic [31:0] exp_fetch;
  int          checks;
  int          errors;
  int          npops;
  logic [31:0] first_pop_pc;
  logic        last_req;
  logic [31:0] last_addr;
  logic        last_valid;
  logic [31:0] last_pc;
  logic        last_excp;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cycle(input logic rdy, input logic acc, input logic rsp,
                       input logic br, input logic [31:0] tgt);
    ent_t  e;
    pend_t p;
    logic  accept;
    out_ready         = rdy;
    br_taken          = br;
    br_target         = tgt;
    inst_sram_addr_ok = acc;
    inst_sram_data_ok = rsp && (pend.size() > 0);
    inst_sram_rdata   = (pend.size() > 0) ? (pend[0].addr ^ KEY) : 32'h0;
    #1;
    last_req   = inst_sram_req;
    last_addr  = inst_sram_addr;
    last_valid = out_valid;
    last_pc    = out_pc;
    last_excp  = out_excp;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    if (br) check("req_during_br", 32'(inst_sram_req), 32'd0);
    accept = inst_sram_req && acc;
    if (accept) begin
      check("fetch_addr", inst_sram_addr, exp_fetch);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (out_valid && rdy && !br && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("head_pc", out_pc, e.pc);
      check("head_inst", out_inst, e.inst);
      check("head_excp", 32'(out_excp), 32'(e.excp));
      if (npops == 0) first_pop_pc = out_pc;
      npops++;
    end
    if (br) begin
      exp_q.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
`ifdef IF_ADEF_EN
      exp_fetch = tgt;
`else
      exp_fetch = {tgt[31:2], 2'b00};
`endif
    end
    if (inst_sram_data_ok) begin
      p = pend.pop_front();
      if (!p.stale) begin
        e.pc   = p.addr;
        e.inst = p.addr ^ KEY;
        e.excp = 1'b0;
        exp_q.push_back(e);
      end
    end
    if (accept) begin
      p.addr  = inst_sram_addr;
      p.stale = 1'b0;
      pend.push_back(p);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    out_ready         = 1'b0;
    br_taken          = 1'b0;
    br_target         = 32'h0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    pend.delete();
    exp_q.delete();
    exp_fetch = RPC;
    npops     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl [12];
  int   first_valid;
  int   pops_before;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk    = 1'b0;
    checks = 0;
    errors = 0;

    // reset state
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_excp", 32'(out_excp), 32'd0);
    check("rst_req", 32'(inst_sram_req), 32'd0);
    rst = 1'b0;

    // back-to-back streaming
    first_valid = -1;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        check("b2b_req0", 32'(last_req), 32'd1);
        check("b2b_addr0", last_addr, RPC);
      end
      if (last_valid && first_valid < 0) first_valid = i;
    end
    check("b2b_first_valid", 32'(first_valid), 32'd2);
    check("b2b_pops", 32'(npops), 32'd12);
    check("b2b_first_pc", first_pop_pc, RPC);

    // credit stall, table driven
    tbl[0]  = '{1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1};
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].rdy, 1'b1, 1'b1, 1'b0, 32'h0);
      check($sformatf("stall_req[%0d]", i), 32'(last_req),
            32'(tbl[i].e_req));
      check($sformatf("stall_valid[%0d]", i), 32'(last_valid),
            32'(tbl[i].e_valid));
    end

    // redirect with three in flight
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("sq_req", 32'(last_req), 32'd1);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h1c000100);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) check("sq_redir_addr", last_addr, 32'h1c000100);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("sq_valid", 32'(last_valid), 32'd1);
    check("sq_first_pc", last_pc, 32'h1c000100);

    // redirect coinciding with data_ok and out_ready
    do_reset();
    rst = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    pops_before = npops;
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h1c000300);
    check("coinc_valid_t", 32'(last_valid), 32'd1);
    check("coinc_no_pop", 32'(npops), 32'(pops_before));
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("coinc_empty", 32'(last_valid), 32'd0);
    check("coinc_addr", last_addr, 32'h1c000300);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check("coinc_next_pc", last_pc, 32'h1c000300);

    // misaligned redirect target
    do_reset();
    rst = 1'b0;
`ifdef IF_ADEF_EN
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h1c000102);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("adef_no_req", 32'(last_req), 32'd0);
    begin
      ent_t x;
      x.pc   = 32'h1c000102;
      x.inst = 32'h0;
      x.excp = 1'b1;
      exp_q.push_back(x);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("adef_valid", 32'(last_valid), 32'd1);
    check("adef_excp", 32'(last_excp), 32'd1);
    check("adef_pc", last_pc, 32'h1c000102);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("adef_halt1", 32'(last_req), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("adef_halt2", 32'(last_req), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h1c000200);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    check("adef_resume_req", 32'(last_req), 32'd1);
    check("adef_resume_addr", last_addr, 32'h1c000200);
`else
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h1c000102);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("mask_req", 32'(last_req), 32'd1);
    check("mask_addr", last_addr, 32'h1c000100);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("mask_valid", 32'(last_valid), 32'd1);
    check("mask_pc", last_pc, 32'h1c000100);
    check("mask_excp", 32'(last_excp), 32'd0);
`endif

    // fetch PC wrap
    do_reset();
    rst = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_req", 32'(last_req), 32'd1);
    check("wrap_addr0", last_addr, 32'hFFFFFFFC);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("wrap_addr1", last_addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch stage with a decoupled prefetch queue. It sits between the instruction SRAM bus and the decode stage. It issues sequential fetch requests through a req/addr_ok/data_ok handshake with up to DEPTH requests in flight. Returned instructions are buffered with their PCs, and on a branch redirect all queued and in-flight fetches are squashed.

## Interface
- RESET_PC, 32'h1c000000: PC of the first fetch after reset.
- DEPTH, 4: prefetch queue entries; power of two, 2..16; also the limit on outstanding requests.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- out_ready  in  1  decode accepts the head entry.
- out_valid  out  1  head entry valid.
- out_pc  out  32  PC of head entry.
- out_inst  out  32  instruction of head entry.
- out_excp  out  1  head entry carries a fetch-address exception; tied 0 when IF_ADEF_EN is undefined.
- br_taken  in  1  single-cycle redirect request from downstream.
- br_target  in  32  redirect PC.
- inst_sram_req  out  1  fetch request valid.
- inst_sram_addr  out  32  fetch address (equals fetch_pc).
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data returned this cycle; responses arrive in order.
- inst_sram_rdata  in  32  returned instruction.

## Operation
- Internal state:
  - fetch_pc: next PC to request.
  - pc_fifo: DEPTH-entry PCs of in-flight requests.
  - queue: DEPTH entries of {pc, inst, excp}.
  - inflight: 0..DEPTH, requests accepted but not yet answered.
  - cancel: 0..DEPTH, responses still to discard.
- Issue:
  - inst_sram_req = !rst & !br_taken & !halt & (queue_count + inflight < DEPTH).
  - On req & addr_ok: push fetch_pc into pc_fifo, inflight += 1, fetch_pc += 4 (32-bit wrap: 0xFFFFFFFC -> 0x0).
- Response:
  - On data_ok with cancel > 0: drop the response, pop pc_fifo, cancel -= 1.
  - On data_ok with cancel == 0: pop pc_fifo and push {pc, rdata, 0} into the queue.
  - In both cases inflight -= 1.
- Output:
  - out_valid = queue non-empty; head fields are driven from registers.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle leave the count unchanged. Pop is valid on a full queue; push onto a full queue cannot occur because of the credit rule.
- Redirect (br_taken=1):
  - fetch_pc <= br_target.
  - Queue cleared.
  - cancel <= inflight after this cycle's data_ok and addr_ok are counted (req is 0 during br_taken, so no new acceptance).
  - halt cleared.
  - Any data_ok in the same cycle is discarded.
  - out_ready is ignored during br_taken.
- A second br_taken while cancel > 0 reloads cancel with the current inflight count. The drop rule stays consistent because pc_fifo is popped on every data_ok.

## Timing
- Reset values:
  - out_valid 0, out_pc 0, out_inst 0, out_excp 0.
  - inst_sram_req 0, fetch_pc RESET_PC.
  - inflight 0, cancel 0, halt 0, queue empty.
  - In-flight bus transactions at reset are not tracked; the bus is reset together with this block.
- First cycle after rst deasserts: inst_sram_req=1, addr=RESET_PC.
- data_ok at cycle t -> out_valid=1 at t+1 (no bypass).
- Back-to-back: with addr_ok and data_ok every cycle and out_ready=1, one instruction per cycle is delivered.
- br_taken at cycle t:
  - out_valid=0 at t+1.
  - req with addr=br_target at t+1.
  - First redirected instruction appears no earlier than one cycle after its data_ok.
- Credit stall: req deasserts in the cycle where queue_count + inflight == DEPTH and resumes the cycle after a pop or a dropped response frees a credit.

## Configuration
- IF_ADEF_EN defined:
  - When fetch_pc[1:0] != 0 and a credit is available, no request is issued.
  - Instead, {fetch_pc, 32'h0, 1} is pushed into the queue (respecting order after inflight entries drain) and halt is set.
  - Fetch stays halted until br_taken.
- IF_ADEF_EN undefined:
  - br_target[1:0] is ignored (fetch_pc[1:0] forced to 0).
  - out_excp is constant 0.
  - halt logic is removed.

## Test plan
- Reset, then addr_ok/data_ok every cycle with rdata=pc^0xA5A5A5A5, out_ready=1 -> out_pc sequence 0x1c000000, 0x1c000004, ..., one per cycle, first out_valid two cycles after first addr_ok.
- out_ready=0, bus always ready, DEPTH=4 -> exactly 4 requests issued, req held 0; then out_ready=1 for one cycle -> one pop, req reasserts next cycle.
- 3 requests in flight, br_taken with br_target=0x1c000100, then 3 data_ok -> all 3 dropped, out_valid stays 0 until the response for 0x1c000100; out_pc=0x1c000100 first.
- br_taken in the same cycle as data_ok and out_ready=1 -> no pop reported, response dropped, queue empty at t+1.
- IF_ADEF_EN, br_target=0x1c000102 -> no req; out_valid=1, out_excp=1, out_pc=0x1c000102; req stays 0 until br_taken to 0x1c000200.
- fetch_pc=0xFFFFFFFC -> next request address 0x00000000.
